// File: rtl/param_reg_pkg.sv
// Shared constants and types for the elastic pipeline register and its bench.
package param_reg_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_D = 3;

  // Enough bits to represent every occupancy value from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [DEF_W-1:0] word_t;

endpackage

// File: rtl/param_pipe_stage.sv
// One elastic stage: a valid bit and a data word that advance only when
// the downstream side can take them.
module param_pipe_stage
  import param_reg_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         src_vld,
  input  logic [W-1:0] src_dat,
  input  logic         dst_rdy,
  output logic         vld,
  output logic [W-1:0] dat,
  output logic         rdy
);

  // An empty stage can always load; a full one only when its content moves on.
  assign rdy = ~vld | dst_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (rdy) begin
      vld <= src_vld;
      if (src_vld) begin
        dat <= src_dat;
      end
    end
  end

endmodule

// File: rtl/param_pipe_reg.sv
// D-stage elastic pipeline register with valid/ready on both sides,
// a synchronous flush and an occupancy counter.
module param_pipe_reg
  import param_reg_pkg::*;
#(
  parameter int  W  = DEF_W,
  parameter int  D  = DEF_D,
  localparam int CW = cnt_width(D)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [D-1:0] vld;
  logic [W-1:0] dat [D];
  logic         push;
  logic         pop;

  // Each stage keeps its ready in its own scalar so the backward chain has no self-dependency.
  for (genvar i = 0; i < D; i++) begin : g_stage
    logic         rdy_s;
    logic         dst_rdy_s;
    logic         src_vld_s;
    logic [W-1:0] src_dat_s;

    if (i == D - 1) begin : g_tail
      assign dst_rdy_s = out_ready;
    end else begin : g_mid
      assign dst_rdy_s = g_stage[i+1].rdy_s;
    end

    if (i == 0) begin : g_head
      assign src_vld_s = push;
      assign src_dat_s = in_data;
    end else begin : g_body
      assign src_vld_s = vld[i-1];
      assign src_dat_s = dat[i-1];
    end

    param_pipe_stage #(.W(W)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .src_vld (src_vld_s),
      .src_dat (src_dat_s),
      .dst_rdy (dst_rdy_s),
      .vld     (vld[i]),
      .dat     (dat[i]),
      .rdy     (rdy_s)
    );
  end

  assign in_ready  = g_stage[0].rdy_s & ~flush;
  assign push      = in_valid & in_ready;
  assign out_valid = vld[D-1];
  assign out_data  = dat[D-1];
  assign pop       = out_valid & out_ready;

  // Simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_param_pipe_reg.sv
// Self-checking bench: directed scenarios plus random traffic checked by a
// queue model in which every item shows up at the output D-1 edges after acceptance at the earliest.
module tb_param_pipe_reg;
  import param_reg_pkg::*;

  localparam int W  = DEF_W;
  localparam int D  = DEF_D;
  localparam int CW = cnt_width(D);

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  word_t         in_data;
  logic          out_valid;
  logic          out_ready;
  word_t         out_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  param_pipe_reg #(.W(W), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got still running, required finished");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: items held in arrival order, each tagged with edges since acceptance.
  typedef struct {
    word_t data;
    int    age;
  } item_t;

  item_t model_q[$];
  bit    mon_en = 1'b0;
  bit    pend_ok = 1'b0;
  bit    pend_clr, pend_pop, pend_push, pend_flush;
  word_t pend_data;
  int    exp_count;
  bit    exp_valid, exp_ready;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_count = model_q.size();
      exp_valid = (exp_count > 0) && (model_q[0].age >= D - 1);
      exp_ready = !flush && ((exp_count < D) || out_ready);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL mon_in_ready t=%0t got %b required %b", $time, in_ready, exp_ready);
      end
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL mon_out_valid t=%0t got %b required %b", $time, out_valid, exp_valid);
      end
      checks++;
      if (count !== CW'(exp_count)) begin
        errors++;
        $display("[TB] FAIL mon_count t=%0t got %0d required %0d", $time, count, exp_count);
      end
      if (exp_valid) begin
        checks++;
        if (out_data !== model_q[0].data) begin
          errors++;
          $display("[TB] FAIL mon_out_data t=%0t got %h required %h", $time, out_data, model_q[0].data);
        end
      end
      pend_clr   = reset;
      pend_pop   = exp_valid && out_ready;
      pend_push  = in_valid && exp_ready;
      pend_flush = flush;
      pend_data  = in_data;
      pend_ok    = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (pend_ok) begin
      pend_ok = 1'b0;
      if (pend_clr) begin
        model_q.delete();
      end else begin
        if (pend_pop) void'(model_q.pop_front());
        if (pend_flush) begin
          model_q.delete();
        end else begin
          foreach (model_q[k]) model_q[k].age++;
          if (pend_push) model_q.push_back('{data: pend_data, age: 0});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== '0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_state k=%0d got v=%b d=%h c=%0d r=%b required v=0 d=00 c=0 r=1",
                 k, out_valid, out_data, count, in_ready);
      end
      if (k < 7) tick();
    end
  endtask

  task automatic test_streaming();
    word_t sd [4];
    sd = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 4);
      in_data  = (k < 4) ? sd[k] : word_t'($urandom);
      tick();
      checks++;
      if (out_valid !== (k >= 2 && k <= 5)) begin
        errors++;
        $display("[TB] FAIL stream_valid k=%0d got %b required %b", k, out_valid, (k >= 2 && k <= 5));
      end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (out_data !== sd[k-2]) begin
          errors++;
          $display("[TB] FAIL stream_data k=%0d got %h required %h", k, out_data, sd[k-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    word_t a [4];
    word_t got [$];
    a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = a[k];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_accept k=%0d got %b required 1", k, in_ready);
      end
      tick();
    end
    in_data = a[3];
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || count !== CW'(3)) begin
        errors++;
        $display("[TB] FAIL bp_full k=%0d got r=%b c=%0d required r=0 c=3", k, in_ready, count);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid) got.push_back(out_data);
      tick();
      if (k == 0) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("[TB] FAIL bp_out_len got %0d required 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== a[k]) begin
        errors++;
        $display("[TB] FAIL bp_out_order k=%0d got %h required %h", k, got[k], a[k]);
      end
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("[TB] FAIL bp_drained got %0d required 0", count);
    end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'hB1; tick();
    in_data = 8'hB2; tick();
    in_data = 8'hB3; tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("[TB] FAIL full_count got %0d required 3", count);
    end
    in_valid  = 1'b1;
    in_data   = 8'hB4;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hB1) begin
      errors++;
      $display("[TB] FAIL full_pushpop got r=%b v=%b d=%h required r=1 v=1 d=b1", in_ready, out_valid, out_data);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== CW'(3) || out_valid !== 1'b1 || out_data !== 8'hB2) begin
      errors++;
      $display("[TB] FAIL full_after got c=%0d v=%b d=%h required c=3 v=1 d=b2", count, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (count !== '0) begin
      errors++;
      $display("[TB] FAIL full_drain got %0d required 0", count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'hC1; tick();
    in_data = 8'hC2; tick();
    in_data = 8'hC5;
    flush   = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || count !== CW'(2)) begin
      errors++;
      $display("[TB] FAIL flush_cycle got r=%b c=%0d required r=0 c=2", in_ready, count);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_clear got c=%0d v=%b required c=0 v=0", count, out_valid);
    end
    out_ready = 1'b1;
    for (int k = 0; k < D + 2; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_no_c5 k=%0d got v=%b d=%h required v=0", k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 8'hE1; tick();
    in_data = 8'hE2; tick();
    in_data = 8'hE3; tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("[TB] FAIL rmid_fill got %0d required 3", count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rmid_cleared got c=%0d v=%b d=%h required c=0 v=0 d=00", count, out_valid, out_data);
    end
    in_valid  = 1'b1;
    in_data   = 8'hD1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if (out_valid !== (k == 2) || (k == 2 && out_data !== 8'hD1)) begin
        errors++;
        $display("[TB] FAIL rmid_latency k=%0d got v=%b d=%h required v=%b d=d1", k, out_valid, out_data, (k == 2));
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(63) == 0);
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = word_t'($urandom);
      tick();
    end
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < D + 2; k++) tick();
    checks++;
    if (count !== '0) begin
      errors++;
      $display("[TB] FAIL rand_drain got %0d required 0", count);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    test_random();
    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
